// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one hold-until-ready memory port between the instruction-fetch
//   requester and the data (M-stage) requester. One access is in flight at a
//   time. Data has fixed priority, so the older instruction always finishes
//   first. A memory that never acknowledges is cut off after TIMEOUT wait
//   cycles and flagged through the sticky err output.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   inst_req/addr             fetch request (held until inst_ready)
//   inst_rdata/ready          fetched word + one-cycle completion pulse
//   data_req/wen/addr/wdata   data request; wen == 0000 means read
//   data_rdata/ready          load data (0 for stores) + completion pulse
//   mem_en/wen/addr/wdata     registered memory request, held until mem_ready
//   mem_rdata/ready           memory response
//   err                       sticky timeout flag, cleared only by reset
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             mem_en_q, mem_en_d;
  logic [3:0]       mem_wen_q, mem_wen_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      inst_rdata_q, inst_rdata_d;
  logic             inst_ready_q, inst_ready_d;
  logic [31:0]      data_rdata_q, data_rdata_d;
  logic             data_ready_q, data_ready_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic             timed_out;
  logic [31:0]      resp_word;

  // The counter holds the number of wait cycles already seen, so with
  // mem_ready stuck low the access is cut off after TIMEOUT+1 access cycles
  // and the ready pulse lands in cycle TIMEOUT+2 after the request edge.
  assign timed_out = (wait_cnt_q == CNT_MAX);

  always_comb begin
    resp_word = mem_rdata;
    if (!mem_ready) begin
      resp_word = TIMEOUT_WORD;
    end else if (state_q == DATA && mem_wen_q != 4'b0000) begin
      // Stores return nothing; give the pipeline a clean zero.
      resp_word = 32'h0;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_en_d     = mem_en_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    err_d        = err_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (data_req) begin
          mem_en_d    = 1'b1;
          mem_wen_d   = data_wen;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          wait_cnt_d  = '0;
          state_d     = DATA;
        end else if (inst_req) begin
          mem_en_d    = 1'b1;
          mem_wen_d   = 4'b0000;
          mem_addr_d  = inst_addr;
          wait_cnt_d  = '0;
          state_d     = INST;
        end
      end

      INST, DATA: begin
        if (mem_ready || timed_out) begin
          if (state_q == INST) begin
            inst_rdata_d = resp_word;
            inst_ready_d = 1'b1;
          end else begin
            data_rdata_d = resp_word;
            data_ready_d = 1'b1;
          end
          if (!mem_ready) begin
            err_d = 1'b1;
          end
          mem_en_d  = 1'b0;
          mem_wen_d = 4'b0000;
          state_d   = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // Requests are deliberately ignored here: the requester is still
      // deciding whether to drop req or present its next access.
      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_en_q     <= 1'b0;
      mem_wen_q    <= 4'b0000;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      inst_rdata_q <= 32'h0;
      inst_ready_q <= 1'b0;
      data_rdata_q <= 32'h0;
      data_ready_q <= 1'b0;
      err_q        <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      inst_ready_q <= inst_ready_d;
      data_rdata_q <= data_rdata_d;
      data_ready_q <= data_ready_d;
      err_q        <= err_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign inst_ready = inst_ready_q;
  assign data_rdata = data_rdata_q;
  assign data_ready = data_ready_q;
  assign err        = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the pipeline's instruction-fetch port and its data (M-stage) port. Both requesters share one unified SRAM/bus port. The arbiter accepts one access at a time, with fixed priority to data so the older instruction always completes first. It drives a hold-until-ready memory handshake, returns read data with a one-cycle `*_ready` pulse, and flags memory that never acknowledges.

## Interface

Parameters:
- `TIMEOUT`, default 255: number of consecutive cycles `mem_ready` may stay low during an access before the access is force-terminated.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `inst_req`, in, 1: fetch request; held high until `inst_ready`.
- `inst_addr`, in, 32: fetch byte address; stable while `inst_req` is high.
- `inst_rdata`, out, 32: fetched word; valid when `inst_ready` is high.
- `inst_ready`, out, 1: one-cycle completion pulse for fetch.
- `data_req`, in, 1: data request; held high until `data_ready`.
- `data_wen`, in, 4: byte write enables; `0000` means read.
- `data_addr`, in, 32: data byte address.
- `data_wdata`, in, 32: store data.
- `data_rdata`, out, 32: load data; valid when `data_ready` is high.
- `data_ready`, out, 1: one-cycle completion pulse for data.
- `mem_en`, out, 1: memory access active.
- `mem_wen`, out, 4: byte write enables to memory.
- `mem_addr`, out, 32: memory address.
- `mem_wdata`, out, 32: memory write data.
- `mem_rdata`, in, 32: memory read data; sampled when `mem_ready` is high.
- `mem_ready`, in, 1: memory acknowledge; may be asserted in the first `mem_en` cycle.
- `err`, out, 1: sticky timeout flag.

## Operation

- FSM states: IDLE, INST, DATA, RESP. All outputs are registered.
- **IDLE**
  - If `data_req` is high: latch `data_addr`, `data_wen` and `data_wdata` into `mem_*`, set `mem_en`=1, go to DATA.
  - Otherwise, if `inst_req` is high: latch `inst_addr`, set `mem_wen`=0000 and `mem_en`=1, go to INST.
  - Otherwise stay in IDLE.
  - Data always wins a simultaneous request.
- **INST / DATA**
  - `mem_*` outputs are held stable.
  - On a cycle with `mem_ready`=1: capture `mem_rdata` into the owner's `*_rdata`, pulse the owner's `*_ready`, clear `mem_en` and `mem_wen`, go to RESP.
  - For a data write (`mem_wen`≠0), `data_rdata` is loaded with 0.
- **RESP**
  - Exactly one cycle; the owner's `*_ready`=1 during it.
  - Requests are not sampled in RESP.
  - Next state is IDLE.
- **Timeout**
  - A wait counter clears on entry to INST/DATA and increments on each cycle with `mem_ready`=0.
  - When the counter reaches `TIMEOUT`, the access terminates as if acknowledged: `*_rdata`=32'hDEADBEEF, `*_ready` pulses, `err` is set, go to RESP.
  - `err` clears only on reset.
- Requester rule: `req` and its address/data are held until `*_ready` is seen. In the `*_ready` cycle the requester either drops `req` or presents its next request, which is sampled in the following IDLE cycle.
- The non-granted requester simply waits. Its `req` stays high, and no output toggles for it.

## Timing

- Reset (asynchronous, `rst`=0): state IDLE; `mem_en`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0, `inst_ready`=0, `data_ready`=0, `inst_rdata`=0, `data_rdata`=0, `err`=0, wait counter 0.
- Reset mid-access abandons the transaction immediately, with `mem_en` dropping asynchronously. No `*_ready` pulse is issued for the abandoned access.
- Latency, with `req` sampled at edge 0:
  - `mem_en` is high from cycle 1.
  - With `mem_ready` high in cycle 1, `*_ready` is high in cycle 2.
  - Each extra wait cycle adds 1.
- Minimum throughput is one access per 3 cycles (IDLE, access, RESP).
- Back-to-back: a data request arriving while a fetch is in progress is granted in the IDLE cycle after that fetch's RESP. The fetch is never preempted.
- Timeout: with `mem_ready` held low, `*_ready` pulses in cycle `TIMEOUT`+2.

## Test plan

- **Reset:** hold `rst`=0 for 3 cycles with both requests high → all outputs 0 and no `mem_en`. After release, the data request is granted first.
- **Fetch with zero-wait memory:** `inst_req` high with `inst_addr`=0x00000040 and `mem_rdata`=0x8C010004 → `mem_en`=1 and `mem_addr`=0x40 in cycle 1; `inst_ready`=1 and `inst_rdata`=0x8C010004 in cycle 2.
- **Simultaneous requests:** data store (addr 0x100, `wen` 0011, `wdata` 0x1234ABCD) and fetch at 0x44 → memory sees the store with `mem_wen`=0011 first. `data_ready` pulses with `data_rdata`=0. The fetch issues in the IDLE cycle after RESP.
- **Wait states:** `mem_ready` delayed 4 cycles on a load from 0x200 returning 0xCAFEF00D → `mem_*` held stable for all 4 wait cycles; `data_ready` in cycle 6 with 0xCAFEF00D.
- **Timeout** (`TIMEOUT`=8): `mem_ready` held low on a fetch → `inst_ready` in cycle 10 with `inst_rdata`=0xDEADBEEF and `err`=1. `err` remains 1 across later successful accesses until reset.
- **Reset mid-access:** assert `rst`=0 in the second wait cycle of a data load → `mem_en` falls without a clock edge and `data_ready` never pulses. After release the arbiter is in IDLE and re-grants the still-held request.
